// File: rtl/wb_mic_capture_if.sv
// Wishbone slave bus bundle for wb_mic_capture.
interface wb_mic_capture_if;
    logic        wb_stb_i;
    logic        wb_cyc_i;
    logic        wb_ack_o;
    logic        wb_we_i;
    logic [31:0] wb_adr_i;
    logic [3:0]  wb_sel_i;
    logic [31:0] wb_dat_i;
    logic [31:0] wb_dat_o;

    modport master (
        output wb_stb_i, wb_cyc_i, wb_we_i, wb_adr_i, wb_sel_i, wb_dat_i,
        input  wb_ack_o, wb_dat_o
    );

    modport slave (
        input  wb_stb_i, wb_cyc_i, wb_we_i, wb_adr_i, wb_sel_i, wb_dat_i,
        output wb_ack_o, wb_dat_o
    );
endinterface

// File: rtl/wb_mic_capture.sv
// Wishbone-mapped edge capture for NCH async mic/event inputs with counters and interrupt.
// Optional per-channel debounce filter enabled by defining WB_MIC_DEBOUNCE_EN.
module wb_mic_capture #(
    parameter int NCH        = 4,
    parameter int CNT_W      = 16,
    parameter int DEB_CYCLES = 16
) (
    input  logic             clk,
    input  logic             reset,
    wb_mic_capture_if.slave  bus,
    input  logic [NCH-1:0]   mic,
    output logic             intr
);
    localparam int unsigned NCHU = NCH;
    localparam logic [CNT_W-1:0] CMAX = '1;

    logic [NCH-1:0]   sync1, sync2, lvl, prev, evt;
    logic [NCH-1:0]   status, mask, rise_en, fall_en, ovf;
    logic [NCH-1:0]   wbits, cnt_clr, ovf_set;
    logic [CNT_W-1:0] count [NCH];
    logic             req, wr, cnt_sel;
    logic [5:0]       widx;
    logic [2:0]       cidx;
    logic [31:0]      rdata;
    logic             unused;

    always_ff @(posedge clk) begin
        if (!reset) begin
            sync1 <= '0;
            sync2 <= '0;
            prev  <= '0;
        end else begin
            sync1 <= mic;
            sync2 <= sync1;
            prev  <= lvl;
        end
    end

`ifdef WB_MIC_DEBOUNCE_EN
    localparam int DW = $clog2(DEB_CYCLES + 1);
    logic [DW-1:0]  deb_cnt [NCH];
    logic [NCH-1:0] filt;

    // Filtered level flips only after DEB_CYCLES consecutive disagreeing samples.
    always_ff @(posedge clk) begin
        for (int unsigned i = 0; i < NCHU; i++) begin
            if (!reset) begin
                filt[i]    <= 1'b0;
                deb_cnt[i] <= '0;
            end else if (sync2[i] != filt[i]) begin
                if (deb_cnt[i] == DW'(DEB_CYCLES - 1)) begin
                    filt[i]    <= sync2[i];
                    deb_cnt[i] <= '0;
                end else begin
                    deb_cnt[i] <= deb_cnt[i] + 1'b1;
                end
            end else begin
                deb_cnt[i] <= '0;
            end
        end
    end

    assign lvl    = filt;
    assign unused = &{1'b0, bus.wb_sel_i, bus.wb_adr_i[31:8], bus.wb_dat_i[31:NCH]};
`else
    assign lvl    = sync2;
    assign unused = &{1'b0, bus.wb_sel_i, bus.wb_adr_i[31:8], bus.wb_dat_i[31:NCH],
                      32'(DEB_CYCLES)};
`endif

    assign evt     = (rise_en & lvl & ~prev) | (fall_en & ~lvl & prev);
    assign req     = bus.wb_stb_i & bus.wb_cyc_i & ~bus.wb_ack_o;
    assign wr      = req & bus.wb_we_i;
    assign widx    = bus.wb_adr_i[7:2];
    assign cidx    = bus.wb_adr_i[4:2];
    assign cnt_sel = (bus.wb_adr_i[7:5] == 3'b001);
    assign wbits   = bus.wb_dat_i[NCH-1:0];

    always_comb begin
        rdata = '0;
        case (widx)
            6'h00: rdata[NCH-1:0] = status;
            6'h01: rdata[NCH-1:0] = mask;
            6'h02: rdata[NCH-1:0] = lvl;
            6'h03: rdata[NCH-1:0] = rise_en;
            6'h04: rdata[NCH-1:0] = fall_en;
            6'h05: rdata[NCH-1:0] = ovf;
            default: begin
                for (int unsigned i = 0; i < NCHU; i++) begin
                    if (cnt_sel && ({29'd0, cidx} == i)) rdata[CNT_W-1:0] = count[i];
                end
            end
        endcase
    end

    // A clear write in the same cycle as an edge leaves COUNT at 1, so it cannot overflow.
    always_comb begin
        cnt_clr = '0;
        ovf_set = '0;
        for (int unsigned i = 0; i < NCHU; i++) begin
            cnt_clr[i] = wr && cnt_sel && ({29'd0, cidx} == i);
            ovf_set[i] = evt[i] && (count[i] == CMAX) && !cnt_clr[i];
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            bus.wb_ack_o <= 1'b0;
            bus.wb_dat_o <= '0;
            intr         <= 1'b0;
            status       <= '0;
            ovf          <= '0;
            mask         <= '0;
            rise_en      <= '1;
            fall_en      <= '0;
            for (int unsigned i = 0; i < NCHU; i++) count[i] <= '0;
        end else begin
            bus.wb_ack_o <= req;
            if (req) bus.wb_dat_o <= rdata;
            intr   <= |(status & mask);
            status <= (status & ~((wr && widx == 6'h00) ? wbits : '0)) | evt;
            ovf    <= (ovf & ~((wr && widx == 6'h05) ? wbits : '0)) | ovf_set;
            if (wr && widx == 6'h01) mask    <= wbits;
            if (wr && widx == 6'h03) rise_en <= wbits;
            if (wr && widx == 6'h04) fall_en <= wbits;
            for (int unsigned i = 0; i < NCHU; i++) begin
                if (cnt_clr[i])
                    count[i] <= evt[i] ? CNT_W'(1) : '0;
                else if (evt[i] && count[i] != CMAX)
                    count[i] <= count[i] + 1'b1;
            end
        end
    end
endmodule

// File: tb/tb_wb_mic_capture.sv
// Randomized self-checking bench for wb_mic_capture against a per-channel event model.
module tb_wb_mic_capture;
    localparam int unsigned NCH  = 4;
    localparam int          DEB  = 16;
    localparam int unsigned MAXC = 255;
`ifdef WB_MIC_DEBOUNCE_EN
    localparam int SETTLE = DEB + 8;
    localparam int LAT    = 2 + DEB;
`else
    localparam int SETTLE = 6;
    localparam int LAT    = 2;
`endif

    logic           clk   = 1'b0;
    logic           reset = 1'b0;
    logic [NCH-1:0] mic   = '0;
    logic           intr;

    wb_mic_capture_if bus ();

    wb_mic_capture #(.NCH(NCH), .CNT_W(8), .DEB_CYCLES(DEB)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus),
        .mic   (mic),
        .intr  (intr)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    int unsigned    cnt_m [NCH];
    logic [NCH-1:0] st_m, ovf_m, mask_m, rise_m, fall_m, mic_m;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        st_m = '0; ovf_m = '0; mask_m = '0; rise_m = '1; fall_m = '0;
        for (int i = 0; i < int'(NCH); i++) cnt_m[i] = 0;
    endtask

    task automatic edge_event(input int ch, input bit rising);
        if ((rising && rise_m[ch]) || (!rising && fall_m[ch])) begin
            st_m[ch] = 1'b1;
            if (cnt_m[ch] == MAXC) ovf_m[ch] = 1'b1;
            else cnt_m[ch]++;
        end
    endtask

    task automatic model_write(input logic [7:0] a, input logic [31:0] d);
        int unsigned idx;
        case (a)
            8'h00: st_m   = st_m & ~d[NCH-1:0];
            8'h04: mask_m = d[NCH-1:0];
            8'h0C: rise_m = d[NCH-1:0];
            8'h10: fall_m = d[NCH-1:0];
            8'h14: ovf_m  = ovf_m & ~d[NCH-1:0];
            default: begin
                if (a >= 8'h20 && a < 8'h40 && a[1:0] == 2'b00) begin
                    idx = (32'(a) - 32'h20) >> 2;
                    if (idx < NCH) cnt_m[idx] = 0;
                end
            end
        endcase
    endtask

    function automatic logic [31:0] exp_reg(input logic [7:0] a);
        int unsigned idx;
        exp_reg = '0;
        case (a)
            8'h00: exp_reg = 32'(st_m);
            8'h04: exp_reg = 32'(mask_m);
            8'h08: exp_reg = 32'(mic_m);
            8'h0C: exp_reg = 32'(rise_m);
            8'h10: exp_reg = 32'(fall_m);
            8'h14: exp_reg = 32'(ovf_m);
            default: begin
                if (a >= 8'h20 && a < 8'h40 && a[1:0] == 2'b00) begin
                    idx = (32'(a) - 32'h20) >> 2;
                    if (idx < NCH) exp_reg = cnt_m[idx];
                end
            end
        endcase
    endfunction

    task automatic bus_xfer(input logic we, input logic [7:0] a, input logic [31:0] d,
                            output logic [31:0] q);
        @(negedge clk);
        bus.wb_stb_i = 1'b1; bus.wb_cyc_i = 1'b1; bus.wb_we_i = we;
        bus.wb_adr_i = {24'd0, a}; bus.wb_sel_i = 4'hF; bus.wb_dat_i = d;
        @(posedge clk); #1;
        check("ack", {31'd0, bus.wb_ack_o}, 32'd1);
        q = bus.wb_dat_o;
        @(negedge clk);
        bus.wb_stb_i = 1'b0; bus.wb_cyc_i = 1'b0; bus.wb_we_i = 1'b0;
        @(posedge clk); #1;
        check("ack_drop", {31'd0, bus.wb_ack_o}, 32'd0);
    endtask

    task automatic wr_m(input logic [7:0] a, input logic [31:0] d);
        logic [31:0] q;
        bus_xfer(1'b1, a, d, q);
        model_write(a, d);
    endtask

    task automatic rd_check(input string tag, input logic [7:0] a);
        logic [31:0] q;
        bus_xfer(1'b0, a, '0, q);
        check(tag, q, exp_reg(a));
    endtask

    task automatic check_intr();
        @(negedge clk);
        check("intr", {31'd0, intr}, {31'd0, |(st_m & mask_m)});
    endtask

    task automatic check_all();
        logic [7:0] a;
        for (int i = 0; i < 17; i++) begin
            a = (i < 6) ? 8'(i * 4) : 8'(32 + (i - 6) * 4);
            rd_check($sformatf("rd_%02h", a), a);
        end
        check_intr();
    endtask

    task automatic toggle(input int ch);
        @(negedge clk);
        mic_m[ch] = ~mic_m[ch];
        mic = mic_m;
        edge_event(ch, mic_m[ch]);
        repeat (SETTLE) @(posedge clk);
    endtask

    initial begin
        #5ms;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] q;
        logic [7:0]  addrs [9];
        logic [7:0]  a;
        int          op, ch;
        logic [31:0] d;

        addrs = '{8'h00, 8'h04, 8'h08, 8'h0C, 8'h10, 8'h14, 8'h20, 8'h2C, 8'h30};
        bus.wb_stb_i = 1'b0; bus.wb_cyc_i = 1'b0; bus.wb_we_i = 1'b0;
        bus.wb_adr_i = '0; bus.wb_sel_i = '0; bus.wb_dat_i = '0;
        mic_m = '0;
        model_reset();

        repeat (3) @(posedge clk);
        #1;
        check("rst_ack", {31'd0, bus.wb_ack_o}, 32'd0);
        check("rst_intr", {31'd0, intr}, 32'd0);
        check("rst_dat", bus.wb_dat_o, 32'd0);
        @(negedge clk);
        reset = 1'b1;
        bus_xfer(1'b0, 8'h0C, '0, q);
        check("rise_en_rst", q, 32'h0000_000F);
        check_all();

        // Single masked rising edge, then W1C.
        wr_m(8'h04, 32'h2);
        toggle(1);
        check_intr();
        rd_check("status_ch1", 8'h00);
        rd_check("count_ch1", 8'h24);
        wr_m(8'h00, 32'h2);
        check_intr();
        check_all();

        for (int it = 0; it < 150; it++) begin
            op = int'($urandom_range(0, 5));
            ch = int'($urandom_range(0, NCH - 1));
            d  = $urandom;
            case (op)
                0, 1: toggle(ch);
                2: begin
                    case ($urandom_range(0, 2))
                        0: a = 8'h04;
                        1: a = 8'h0C;
                        default: a = 8'h10;
                    endcase
                    wr_m(a, d);
                end
                3: wr_m(($urandom_range(0, 1) != 0) ? 8'h00 : 8'h14, d);
                4: wr_m(8'h20 + 8'($urandom_range(0, 7) * 4), d);
                default: begin
                    a = addrs[$urandom_range(0, 8)];
                    rd_check("rand_rd", a);
                end
            endcase
            check_intr();
        end
        check_all();

        // Saturation and overflow on ch0.
        wr_m(8'h0C, 32'h1);
        wr_m(8'h10, 32'h0);
        wr_m(8'h14, 32'hF);
        if (mic_m[0]) toggle(0);
        wr_m(8'h20, 32'h0);
        repeat (258) begin
            toggle(0);
            toggle(0);
        end
        bus_xfer(1'b0, 8'h20, '0, q);
        check("count0_sat", q, 32'd255);
        bus_xfer(1'b0, 8'h14, '0, q);
        check("ovf0", q, 32'h1);
        wr_m(8'h20, 32'h0);
        rd_check("count0_clr", 8'h20);

        // W1C of STATUS[0] landing on the edge that sets it.
        toggle(0);
        toggle(0);
        @(negedge clk);
        mic_m[0] = 1'b1;
        mic = mic_m;
        repeat (LAT) @(posedge clk);
        bus_xfer(1'b1, 8'h00, 32'h1, q);
        model_write(8'h00, 32'h1);
        edge_event(0, 1'b1);
        repeat (SETTLE) @(posedge clk);
        bus_xfer(1'b0, 8'h00, '0, q);
        check("w1c_race_status", {31'd0, q[0]}, 32'd1);
        rd_check("w1c_race_count", 8'h20);

        // COUNT[0] clear landing on a counted edge.
        toggle(0);
        @(negedge clk);
        mic_m[0] = 1'b1;
        mic = mic_m;
        repeat (LAT) @(posedge clk);
        bus_xfer(1'b1, 8'h20, 32'h0, q);
        model_write(8'h20, 32'h0);
        edge_event(0, 1'b1);
        repeat (SETTLE) @(posedge clk);
        bus_xfer(1'b0, 8'h20, '0, q);
        check("clr_race_count", q, 32'd1);

        // Falling-edge only counting, then an unmapped read.
        toggle(0);
        wr_m(8'h0C, 32'h0);
        wr_m(8'h10, 32'h1);
        wr_m(8'h20, 32'h0);
        toggle(0);
        toggle(0);
        bus_xfer(1'b0, 8'h20, '0, q);
        check("fall_count", q, 32'd1);
        bus_xfer(1'b0, 8'h40, '0, q);
        check("unmapped_40", q, 32'd0);
        check_all();

`ifdef WB_MIC_DEBOUNCE_EN
        wr_m(8'h0C, 32'hF);
        wr_m(8'h10, 32'h0);
        if (mic_m[2]) toggle(2);
        @(negedge clk);
        mic[2] = 1'b1;
        repeat (10) @(negedge clk);
        mic[2] = 1'b0;
        repeat (SETTLE) @(posedge clk);
        check_all();
        @(negedge clk);
        mic_m[2] = 1'b1;
        mic = mic_m;
        edge_event(2, 1'b1);
        repeat (20) @(negedge clk);
        mic_m[2] = 1'b0;
        mic = mic_m;
        edge_event(2, 1'b0);
        repeat (SETTLE) @(posedge clk);
        check_all();
`endif

        // Reset during a write: access aborted, high inputs yield one rising edge.
        if (!mic_m[3]) toggle(3);
        if (mic_m[1]) toggle(1);
        @(negedge clk);
        bus.wb_stb_i = 1'b1; bus.wb_cyc_i = 1'b1; bus.wb_we_i = 1'b1;
        bus.wb_adr_i = 32'h4; bus.wb_dat_i = 32'hF;
        reset = 1'b0;
        @(posedge clk); #1;
        check("abort_ack", {31'd0, bus.wb_ack_o}, 32'd0);
        check("abort_intr", {31'd0, intr}, 32'd0);
        @(negedge clk);
        bus.wb_stb_i = 1'b0; bus.wb_cyc_i = 1'b0; bus.wb_we_i = 1'b0;
        reset = 1'b1;
        model_reset();
        for (int i = 0; i < int'(NCH); i++) if (mic_m[i]) edge_event(i, 1'b1);
        repeat (SETTLE) @(posedge clk);
        check_all();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/wb_mic_capture.md
WB_MIC_CAPTURE -- requirements
Module: wb_mic_capture

Interface
REQ-001 Parameter NCH, default 4, number of microphone/event input channels (1..8).
REQ-002 Parameter CNT_W, default 16, width of each per-channel event counter (8..32).
REQ-003 Parameter DEB_CYCLES, default 16, debounce stability window in clk cycles (used only with WB_MIC_DEBOUNCE_EN).
REQ-004 clk  input  1  sole clock; all state updates on its rising edge.
REQ-005 reset  input  1  synchronous, active-low reset; reset=0 sampled at a clk rising edge resets the block.
REQ-006 wb_stb_i  input  1  Wishbone strobe.
REQ-007 wb_cyc_i  input  1  Wishbone cycle.
REQ-008 wb_ack_o  output  1  Wishbone acknowledge.
REQ-009 wb_we_i  input  1  1 = write, 0 = read.
REQ-010 wb_adr_i  input  32  byte address; only bits [7:0] decoded.
REQ-011 wb_sel_i  input  4  byte selects; ignored, all accesses full-word.
REQ-012 wb_dat_i  input  32  write data.
REQ-013 wb_dat_o  output  32  read data, registered.
REQ-014 mic  input  NCH  asynchronous channel inputs.
REQ-015 intr  output  1  level interrupt = OR of (STATUS & MASK), registered.

Function
REQ-016 Each mic bit passes a 2-flop synchronizer; the synchronized level feeds a previous-level register for edge detection.
REQ-017 Without debounce, a mic transition stable before clk edge 1 sets its STATUS bit at edge 3; intr asserts at edge 4 if masked in.
REQ-018 Rising edge on channel i counts when RISE_EN[i]=1; falling edge counts when FALL_EN[i]=1; a counted edge sets STATUS[i] and increments COUNT[i].
REQ-019 COUNT[i] saturates at 2^CNT_W-1; further edges still set STATUS[i] and set OVF[i] (sticky).
REQ-020 Register map: 0x00 STATUS (RW1C), 0x04 MASK (RW), 0x08 LEVEL (RO, filtered levels), 0x0C RISE_EN (RW), 0x10 FALL_EN (RW), 0x14 OVF (RW1C), 0x20+4*i COUNT[i] (read; any write clears to 0).
REQ-021 Register fields are bits [NCH-1:0] (COUNT: [CNT_W-1:0]); unused bits read 0; unmapped or i>=NCH addresses read 0, writes ignored, still acked.
REQ-022 Handshake: when wb_stb_i&wb_cyc_i and ack=0, ack and wb_dat_o are registered next edge; ack is high exactly one cycle, then low at least one cycle (no back-to-back acks).
REQ-023 Write side effects occur on the same edge that raises wb_ack_o; read data reflects state before that edge.
REQ-024 Simultaneous W1C of STATUS[i]/OVF[i] and new set event on i in the same cycle: bit remains 1 (set wins).
REQ-025 Simultaneous COUNT[i] clear write and counted edge: COUNT[i] becomes 1.
REQ-026 Reading STATUS has no side effect.
REQ-027 MASK changes affect intr on the next edge; STATUS bits set while masked remain pending.

Reset
REQ-028 On reset: wb_ack_o=0, wb_dat_o=0, intr=0, STATUS=0, OVF=0, MASK=0, RISE_EN=all 1, FALL_EN=0, all COUNT=0.
REQ-029 On reset synchronizer and previous-level registers load current filtered-path reset value 0; an input already high after reset yields one rising edge, counted only if still enabled.
REQ-030 Reset asserted mid-transaction drops wb_ack_o next edge; the aborted access has no side effect.

Configuration
REQ-031 Macro WB_MIC_DEBOUNCE_EN defined: per channel, filtered level updates only after the synchronized level differs from it for DEB_CYCLES consecutive cycles; glitches shorter are discarded; latency grows by DEB_CYCLES.
REQ-032 Macro undefined: filtered level equals synchronized level; DEB_CYCLES unused; no debounce counters synthesized.

Verification
REQ-033 Reset release, read 0x0C -> 0x0000000F (NCH=4); reads of 0x00,0x04,0x20 -> 0; ack exactly one cycle per access.
REQ-034 mic[1] 0->1, MASK=0x2 -> STATUS=0x2, COUNT[1]=1, intr=1; write 0x2 to 0x00 -> STATUS=0, intr=0 next edge.
REQ-035 CNT_W=8, 256 rising edges on ch0 -> COUNT[0]=255, OVF=0x1; write to 0x20 -> COUNT[0]=0.
REQ-036 W1C of STATUS[0] issued same cycle as detected edge on ch0 -> STATUS[0] stays 1, COUNT[0] increments.
REQ-037 With WB_MIC_DEBOUNCE_EN, DEB_CYCLES=16: 10-cycle pulse on mic[2] -> no STATUS/COUNT change; 20-cycle pulse -> COUNT[2]=1.
REQ-038 FALL_EN=0x1, RISE_EN=0: ch0 pulse 0->1->0 -> COUNT[0]=1; read 0x40 -> 0, acked.
